// File: rtl/mnist_rx_pkg.sv
// Shared constants, state encoding and pixel addressing for the MNIST frame receiver.
package mnist_rx_pkg;
    localparam int IMG_W           = 16;
    localparam int IMG_BITS        = 256;
    localparam int BYTES_PER_FRAME = 32;
    localparam int INDEX_W         = 4;

    typedef enum logic {
        ST_IDLE,
        ST_FILL
    } rx_state_e;

    // Pixel (r,c) lives at this bit of the flat image vector; row 0 is the MSBs.
    function automatic int pixel_bit(input int r, input int c);
        return IMG_BITS - 1 - (IMG_W * r + c);
    endfunction
endpackage

// File: rtl/mnist_frame_receiver_if.sv
// Byte stream in, image/class results out; master drives bytes, slave is the receiver.
interface mnist_frame_receiver_if #(
    parameter int INDEX_W = 4
);
    logic [7:0]         byte_in;
    logic               byte_en;
    logic               sof;
    logic [255:0]       image;
    logic               image_valid;
    logic [INDEX_W-1:0] class_in;
    logic [INDEX_W-1:0] class_out;
    logic               class_valid;
    logic               frame_abort;
    logic [7:0]         frame_count;

    modport master (
        output byte_in, byte_en, sof, class_in,
        input  image, image_valid, class_out, class_valid, frame_abort, frame_count
    );

    modport slave (
        input  byte_in, byte_en, sof, class_in,
        output image, image_valid, class_out, class_valid, frame_abort, frame_count
    );
endinterface

// File: rtl/mnist_frame_receiver_valid_delay_line.sv
// Delays a valid strobe by DEPTH cycles; DEPTH=0 degenerates to a wire.
module valid_delay_line #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out
);
    generate
        if (DEPTH == 0) begin : g_wire
            assign out = in;
        end else begin : g_pipe
            logic [DEPTH-1:0] vld_pipe;

            // Each stage holds its own strobe, so back-to-back pulses never collide.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) vld_pipe <= '0;
                else     vld_pipe <= (vld_pipe << 1) | DEPTH'(in);
            end

            assign out = vld_pipe[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/mnist_frame_receiver.sv
// Assembles pixel bytes into a 16x16 binary image and captures the classifier's answer.
module mnist_frame_receiver #(
    parameter int BYTES_PER_FRAME    = 32,
    parameter int CLASSIFIER_LATENCY = 2,
    parameter int INDEX_W            = 4
) (
    input logic               clk,
    input logic               rst,
    mnist_frame_receiver_if.slave bus
);
    import mnist_rx_pkg::*;

    localparam int               CNT_W = $clog2(BYTES_PER_FRAME);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(BYTES_PER_FRAME - 1);

    rx_state_e           state;
    logic [CNT_W-1:0]    byte_cnt;
    logic [CNT_W-1:0]    wr_idx;
    logic [IMG_BITS-1:0] asm_q;
    logic [IMG_BITS-1:0] asm_next;
    logic                restart;
    logic                done;
    logic                cls_sample;

    // sof always lands its byte at slot 0; it only aborts if a partial frame exists.
    assign wr_idx  = bus.sof ? '0 : byte_cnt;
    assign restart = bus.byte_en && bus.sof && (state == ST_FILL) && (byte_cnt != '0);
    assign done    = bus.byte_en && (wr_idx == LAST);

    always_comb begin
        asm_next = asm_q;
        asm_next[IMG_BITS - 1 - 8 * int'(wr_idx) -: 8] = bus.byte_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            byte_cnt        <= '0;
            asm_q           <= '0;
            bus.image       <= '0;
            bus.image_valid <= 1'b0;
            bus.frame_abort <= 1'b0;
            bus.frame_count <= '0;
        end else begin
            bus.image_valid <= 1'b0;
            bus.frame_abort <= 1'b0;
            if (bus.byte_en) begin
                asm_q           <= asm_next;
                bus.frame_abort <= restart;
                if (done) begin
                    bus.image       <= asm_next;
                    bus.image_valid <= 1'b1;
                    bus.frame_count <= bus.frame_count + 8'd1;
                    byte_cnt        <= '0;
                    state           <= ST_IDLE;
                end else begin
                    byte_cnt <= wr_idx + 1'b1;
                    state    <= ST_FILL;
                end
            end
        end
    end

    valid_delay_line #(
        .DEPTH(CLASSIFIER_LATENCY)
    ) u_dly (
        .clk(clk),
        .rst(rst),
        .in (bus.image_valid),
        .out(cls_sample)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.class_out   <= '0;
            bus.class_valid <= 1'b0;
        end else begin
            bus.class_valid <= cls_sample;
            if (cls_sample) bus.class_out <= bus.class_in;
        end
    end
endmodule

// File: tb/tb_mnist_frame_receiver.sv
// Randomized bench for mnist_frame_receiver against a byte-list reference model.
module tb_mnist_frame_receiver;
    import mnist_rx_pkg::*;

    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mnist_frame_receiver_if #(.INDEX_W(4)) bus();

    mnist_frame_receiver #(
        .BYTES_PER_FRAME(32),
        .CLASSIFIER_LATENCY(LAT),
        .INDEX_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is simply the list of bytes accepted since it began.
    int unsigned  cyc = 0;
    logic [7:0]   frame_q[$];
    int unsigned  due_q[$];
    logic [255:0] exp_img = '0;
    logic         exp_iv = 1'b0, exp_abort = 1'b0, exp_cv = 1'b0;
    logic [3:0]   exp_cls = '0;
    logic [7:0]   exp_fc = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q.delete();
            due_q.delete();
            exp_img = '0; exp_iv = 0; exp_abort = 0; exp_cv = 0; exp_cls = '0; exp_fc = '0;
        end else begin
            cyc++;
            exp_iv = 0; exp_abort = 0; exp_cv = 0;
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                void'(due_q.pop_front());
                exp_cls = bus.class_in;
                exp_cv  = 1;
            end
            if (bus.byte_en) begin
                if (bus.sof && frame_q.size() != 0) begin
                    exp_abort = 1;
                    frame_q.delete();
                end
                frame_q.push_back(bus.byte_in);
                if (frame_q.size() == 32) begin
                    for (int i = 0; i < 32; i++) exp_img[255 - 8*i -: 8] = frame_q[i];
                    exp_iv = 1;
                    exp_fc = exp_fc + 8'd1;
                    frame_q.delete();
                    due_q.push_back(cyc + 1 + LAT);
                end
            end
        end
    end

    // Compare process plus event bookkeeping for the hand-written checks.
    int iv_cnt = 0, abort_cnt = 0;
    int unsigned iv_cyc = 0, cv_cyc = 0;

    always @(negedge clk) begin
        chk("image",       256'(bus.image),       exp_img);
        chk("image_valid", 256'(bus.image_valid), 256'(exp_iv));
        chk("frame_abort", 256'(bus.frame_abort), 256'(exp_abort));
        chk("frame_count", 256'(bus.frame_count), 256'(exp_fc));
        chk("class_valid", 256'(bus.class_valid), 256'(exp_cv));
        chk("class_out",   256'(bus.class_out),   256'(exp_cls));
        if (bus.image_valid) begin iv_cnt++; iv_cyc = cyc; end
        if (bus.class_valid) cv_cyc = cyc;
        if (bus.frame_abort) abort_cnt++;
    end

    bit cls_fixed = 1'b0;

    task automatic drive(input logic en, input logic [7:0] b, input logic s);
        @(negedge clk); #1;
        bus.byte_en  = en;
        bus.byte_in  = b;
        bus.sof      = s;
        bus.class_in = cls_fixed ? 4'd9 : 4'($urandom_range(0, 15));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst = 1'b1;
        bus.byte_en = 1'b0;
        bus.sof = 1'b0;
        #1;
        chk("rst_image", 256'(bus.image), '0);
        chk("rst_iv",    256'(bus.image_valid), '0);
        chk("rst_fc",    256'(bus.frame_count), '0);
        chk("rst_cls",   256'({bus.class_out, bus.class_valid, bus.frame_abort}), '0);
        @(negedge clk); @(negedge clk); #1;
        rst = 1'b0;
    endtask

    logic [7:0]   data[32];
    logic [255:0] img_a;

    initial begin
        bus.byte_en = 0; bus.byte_in = 0; bus.sof = 0; bus.class_in = 0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;

        // Free-running frame 0x00..0x1F with class_in held at 9.
        cls_fixed = 1'b1;
        iv_cnt = 0;
        for (int k = 0; k < 32; k++) drive(1'b1, 8'(k), 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        chk("free_iv_now", 256'(bus.image_valid), 256'(1));
        chk("free_top",    256'(bus.image[255:248]), 256'(8'h00));
        chk("free_bot",    256'(bus.image[7:0]),     256'(8'h1F));
        chk("free_fc",     256'(bus.frame_count),    256'(1));
        idle(6);
        chk("free_iv_cnt", 256'(iv_cnt), 256'(1));
        chk("lat_cv_gap",  256'(cv_cyc - iv_cyc), 256'(3));
        chk("lat_cls",     256'(bus.class_out), 256'(9));
        cls_fixed = 1'b0;

        // Pixel mapping: byte 2 = 0x80 sets pixel (1,0).
        for (int k = 0; k < 32; k++) drive(1'b1, (k == 2) ? 8'h80 : 8'h00, k == 0);
        idle(2);
        chk("pix_239",  256'(bus.image[pixel_bit(1, 0)]), 256'(1));
        chk("pix_ones", 256'($countones(bus.image)), 256'(1));

        // Abort: 10 bytes, then sof with 0xAA, then 31 more.
        do_reset();
        abort_cnt = 0;
        for (int k = 0; k < 10; k++) drive(1'b1, 8'($urandom), k == 0);
        drive(1'b1, 8'hAA, 1'b1);
        for (int k = 0; k < 31; k++) drive(1'b1, 8'($urandom), 1'b0);
        idle(2);
        chk("abort_cnt", 256'(abort_cnt), 256'(1));
        chk("abort_top", 256'(bus.image[255:248]), 256'(8'hAA));
        chk("abort_fc",  256'(bus.frame_count), 256'(1));

        // Gaps: same data gapless then with random idle cycles.
        for (int k = 0; k < 32; k++) data[k] = 8'($urandom);
        for (int k = 0; k < 32; k++) drive(1'b1, data[k], k == 0);
        idle(2);
        img_a = bus.image;
        for (int k = 0; k < 32; k++) begin
            drive(1'b1, data[k], k == 0);
            idle($urandom_range(0, 3));
            if (k == 16) chk("gap_stable", bus.image, img_a);
        end
        idle(2);
        chk("gap_same", bus.image, img_a);

        // Reset mid-fill, then a full frame.
        for (int k = 0; k < 20; k++) drive(1'b1, 8'($urandom), 1'b0);
        do_reset();
        iv_cnt = 0;
        for (int k = 0; k < 31; k++) drive(1'b1, 8'($urandom), 1'b0);
        idle(1);
        chk("rstfill_no_iv", 256'(iv_cnt), 256'(0));
        drive(1'b1, 8'h5A, 1'b0);
        idle(2);
        chk("rstfill_iv", 256'(iv_cnt), 256'(1));
        chk("rstfill_bot", 256'(bus.image[7:0]), 256'(8'h5A));

        // Random traffic.
        for (int i = 0; i < 3000; i++)
            drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 40) == 0);
        idle(LAT + 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mnist_frame_receiver.md
# mnist_frame_receiver

Receiving end of the byte-serial image stream that feeds the LGN MNIST classifier. Accepts 8-bit pixel bytes, two per row, and assembles them into a 16×16 one-bit image register. Presents the completed image to the classifier with a one-cycle valid strobe, then captures the classifier's 4-bit digit index after a fixed latency. Sits between the chip's `ui_in` byte port and the classifier core, and replaces ad-hoc byte counting in board tops.

## Interface

Parameters:
- `BYTES_PER_FRAME`, default 32: bytes per image (16 rows × 2 bytes).
- `CLASSIFIER_LATENCY`, default 2: cycles from `image_valid` to a valid `class_in`. Legal range is 0..31.
- `INDEX_W`, default 4: width of the class index.

Ports:
- `clk`, input, 1: single clock for the whole block.
- `rst`, input, 1: reset. **Asynchronous, active-high.**
- `byte_in`, input, 8: pixel byte. MSB is the leftmost pixel.
- `byte_en`, input, 1: `byte_in` is valid this cycle.
- `sof`, input, 1: start of frame. Only meaningful together with `byte_en`; the byte accepted with it becomes byte 0.
- `image`, output, 256: last completed image. Pixel (r,c) is `image[255-(16r+c)]`.
- `image_valid`, output, 1: one-cycle strobe marking that `image` has just been updated.
- `class_in`, input, `INDEX_W`: digit index from the classifier.
- `class_out`, output, `INDEX_W`: latched digit index.
- `class_valid`, output, 1: one-cycle strobe marking that `class_out` has just been updated.
- `frame_abort`, output, 1: one-cycle strobe when a partial frame is discarded.
- `frame_count`, output, 8: count of completed frames. Wraps 255→0.

## Operation

- **States:**
  - IDLE: no bytes held.
  - FILL: 1..31 bytes held.
  - No separate WAIT state; classifier latency is tracked by a valid delay line.
- **Byte placement:** byte k (0-based) goes to bits `[255-8k : 248-8k]` of an internal assembly register. Row r is bytes 2r and 2r+1.
- **Accepting a byte:** when `byte_en`=1, the byte is written at index `byte_cnt`, then `byte_cnt` increments.
- **Without `sof`:** the stream free-runs; byte 0 follows byte 31 with no gap.
- **`sof` in IDLE,** or in FILL exactly when `byte_cnt`=0: the byte is written as byte 0 and the state becomes FILL.
- **`sof` in FILL with `byte_cnt`≠0:**
  - the partial frame is discarded and `frame_abort` pulses;
  - the current byte is written as byte 0;
  - `byte_cnt` becomes 1.
- **Frame completion:** when byte 31 is accepted:
  - the assembly register, with byte 31 merged in, is copied to `image`;
  - `image_valid` pulses;
  - `frame_count` increments;
  - `byte_cnt` returns to 0 and the state returns to IDLE.
- **Stable output:** `image` holds its value between completions. Fill activity never disturbs it.
- **`byte_en`=0:** no state change. Gaps of any length between bytes are legal.
- **Latency tracking:** a shift register of depth `CLASSIFIER_LATENCY` delays `image_valid`. When its output is 1:
  - `class_in` is sampled into `class_out`;
  - `class_valid` pulses on the following cycle.
- **`CLASSIFIER_LATENCY`=0:** `class_in` is sampled in the same cycle that `image_valid`=1.
- **Overlapping frames:** a second frame cannot complete within 32 cycles, so latency tracking never overlaps. A pipelined delay line is still required, with no single busy flag.

## Timing

- **Reset values** (asserted anytime, async): `image`=0, `image_valid`=0, `class_out`=0, `class_valid`=0, `frame_abort`=0, `frame_count`=0, `byte_cnt`=0, state IDLE, delay line cleared.
- **Reset during FILL** discards the frame and emits no strobe.
- **Image latency:** byte 31 is accepted on edge E. `image` and `image_valid` are updated on edge E (registered outputs, visible in the cycle after E).
- **Class sampling:** `class_in` is sampled `CLASSIFIER_LATENCY` cycles after `image_valid` is high. `class_out` and `class_valid` are visible 1 cycle after sampling.
- **Class timeline:** `class_valid` rises `CLASSIFIER_LATENCY`+1 cycles after `image_valid`.
- **`frame_abort`:** coincides with the cycle after the offending `sof` edge.
- **Throughput:** one byte per cycle. Back-to-back frames give `image_valid` every 32 cycles.
- **No combinational input→output paths.**

## Structure

- **Package `mnist_rx_pkg`:**
  - `IMG_W`=16, `IMG_BITS`=256, `BYTES_PER_FRAME`=32, `INDEX_W`=4;
  - the pixel index function (r,c)→bit.
- **Sub-module `valid_delay_line`:**
  - parameter `DEPTH`, with `DEPTH`=0 being a wire;
  - ports `clk`, `rst`, `in`, `out`.
- **Everything else** stays in `mnist_frame_receiver`: byte counter, assembly register, output registers.

## Test plan

- **Free-running frame:** with no `sof`, stream bytes 0x00..0x1F on consecutive cycles.
  - `image_valid` pulses once, 1 cycle after byte 0x1F.
  - `image[255:248]`=0x00 and `image[7:0]`=0x1F.
  - `frame_count`=1.
- **Pixel mapping:** send a frame with byte 2=0x80 and all other bytes 0x00.
  - Only pixel (1,0), i.e. `image[239]`, is set.
- **Latency:** with `CLASSIFIER_LATENCY`=2, hold `class_in`=9 from 2 cycles after `image_valid` onward.
  - `class_out`=9, and `class_valid` pulses exactly 3 cycles after `image_valid`.
- **Abort:** send 10 bytes, then `sof` with byte 0xAA, then 31 more bytes.
  - `frame_abort` pulses once.
  - The completed image has top byte 0xAA.
  - `frame_count`=1.
- **Gaps:** deassert `byte_en` randomly between the 32 bytes of a frame.
  - The image is identical to the gapless run.
  - `image` stays unchanged during the fill.
- **Reset:** assert `rst` mid-fill after 20 bytes, then send a full frame.
  - No `image_valid` during or after reset until the new frame's byte 31.
  - All outputs are 0 during reset.
